cfu_op_sequencer: RTL and testbench
===================================

CFU_OP_SEQUENCER -- requirements
Module: cfu_op_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, the maximum WAIT cycles before a timeout response (only used when CFU_SEQ_TIMEOUT_EN is defined).
REQ-002 SHALL have parameter STATUS_FUNCT7, default 7'h7F, the funct7 code answered locally with the status word.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  CPU command valid.
REQ-006 SHALL have port cmd_ready  output  1  sequencer accepts a command.
REQ-007 SHALL have port cmd_payload_function_id  input  10  funct7 in [9:3], funct3 in [2:0] (funct3 ignored).
REQ-008 SHALL have port cmd_payload_inputs_0  input  32  operand 0.
REQ-009 SHALL have port cmd_payload_inputs_1  input  32  operand 1.
REQ-010 SHALL have port rsp_valid  output  1  response valid.
REQ-011 SHALL have port rsp_ready  input  1  CPU accepts the response.
REQ-012 SHALL have port rsp_payload_outputs_0  output  32  response data.
REQ-013 SHALL have port dp_en  output  1  one-cycle datapath issue strobe.
REQ-014 SHALL have port dp_cmd  output  7  funct7 forwarded to the datapath.
REQ-015 SHALL have ports dp_inp0, dp_inp1  output  32 each  registered operands.
REQ-016 SHALL have port dp_ret  input  32  datapath result.
REQ-017 SHALL have port dp_done  input  1  datapath result valid on dp_ret this cycle.

Function
REQ-018 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; cmd_ready = (state==IDLE); rsp_valid = (state==RESP).
REQ-019 SHALL, in IDLE with cmd_valid, register funct7 and both operands; go to RESP with the status word if funct7==STATUS_FUNCT7, else go to ISSUE.
REQ-020 SHALL, in ISSUE, drive dp_en=1 for exactly one cycle with dp_cmd/dp_inp0/dp_inp1 equal to the captured values; dp_cmd/dp_inp* SHALL hold those values until the next accept.
REQ-021 SHALL, if dp_done=1 in ISSUE, capture dp_ret and go to RESP; otherwise go to WAIT.
REQ-022 SHALL, in WAIT, keep dp_en=0 and, on dp_done=1, capture dp_ret and go to RESP.
REQ-023 SHALL ignore dp_done in IDLE and RESP.
REQ-024 SHALL hold rsp_payload_outputs_0 stable while rsp_valid=1; on rsp_ready=1 go to IDLE; there SHALL be no same-cycle response/accept overlap.
REQ-025 SHALL give latency: accept at cycle N, dp_en at N+1, earliest rsp_valid at N+2; status command rsp_valid at N+1.
REQ-026 SHALL form the status word as [31:16] completed datapath ops (wraps mod 2^16), [15:8] timeout count (saturates at 255), [7:1] last dispatched funct7, [0] 0.
REQ-027 SHALL count a datapath op as completed on the transition into RESP from ISSUE/WAIT via dp_done; status commands SHALL NOT count.

Reset
REQ-028 SHALL, on reset_n=0, immediately force state IDLE, rsp_valid=0, dp_en=0, rsp_payload_outputs_0=0, dp_cmd=0, dp_inp0=0, dp_inp1=0, and all counters 0.
REQ-029 SHALL, on reset asserted mid-ISSUE/WAIT/RESP, abandon the operation with no response after release; cmd_ready=1 in the first cycle after release.

Configuration
REQ-030 SHALL, with CFU_SEQ_TIMEOUT_EN defined, count WAIT cycles and, after TIMEOUT_CYCLES consecutive WAIT cycles without dp_done, go to RESP with payload {16'hDEAD, 9'b0, funct7} and increment the timeout count; dp_done arriving in the same cycle as expiry SHALL win.
REQ-031 SHALL, without CFU_SEQ_TIMEOUT_EN, wait in WAIT indefinitely, omit the timeout counter logic, and read status [15:8] as 0.

Structure
REQ-032 SHALL place the FSM state enum, default STATUS_FUNCT7, the 16'hDEAD timeout tag and the status field widths in package cfu_seq_pkg.
REQ-033 SHALL implement the op and timeout counters in sub-module cfu_seq_counters.

Verification
REQ-034 SHALL cover: funct7=3, inputs 5/7, dp_done 4 cycles after dp_en with dp_ret=0x23 -> single dp_en pulse, dp_cmd=3, rsp payload 0x23, rsp_valid 5 cycles after dp_en.
REQ-035 SHALL cover: dp_done coincident with dp_en, dp_ret=0x1 -> rsp_valid at N+2, WAIT skipped.
REQ-036 SHALL cover: rsp_ready held 0 for 6 cycles -> payload stable, cmd_ready=0, a second cmd_valid not accepted.
REQ-037 SHALL cover: three ops then funct7=0x7F -> payload 0x0003_0006 when the last op used funct7=3; dp_en never pulses for the status command.
REQ-038 SHALL cover: TIMEOUT_CYCLES=8 with macro defined, dp_done never asserted, funct7=3 -> payload 0xDEAD_0003 after 8 WAIT cycles, status [15:8]=1.
REQ-039 SHALL cover: reset_n pulsed low during WAIT -> outputs 0 asynchronously, no response after release, next command processed normally.

Source files
------------

// File: rtl/cfu_seq_pkg.sv
// Shared types and constants for the CFU op sequencer: FSM state encoding,
// status-word field widths, the local status funct7 and the timeout tag.
package cfu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_t;

  localparam logic [6:0]  STATUS_FUNCT7_DEF = 7'h7F;
  localparam logic [15:0] TIMEOUT_TAG       = 16'hDEAD;

  localparam int unsigned OP_CNT_W = 16;
  localparam int unsigned TO_CNT_W = 8;
  localparam int unsigned FUNCT7_W = 7;

  // Status word: {ops completed, timeouts, last dispatched funct7, 1'b0}.
  function automatic logic [31:0] status_word(
    input logic [OP_CNT_W-1:0] ops,
    input logic [TO_CNT_W-1:0] tos,
    input logic [FUNCT7_W-1:0] f7
  );
    return {ops, tos, f7, 1'b0};
  endfunction

endpackage

// File: rtl/cfu_seq_counters.sv
// Completed-op counter (wraps) and timeout counter (saturates).
// The timeout counter exists only when CFU_SEQ_TIMEOUT_EN is defined.
module cfu_seq_counters
  import cfu_seq_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                op_done,
  input  logic                timeout_hit,
  output logic [OP_CNT_W-1:0] op_count,
  output logic [TO_CNT_W-1:0] timeout_count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count <= '0;
    end else if (op_done) begin
      op_count <= op_count + OP_CNT_W'(1);
    end
  end

`ifdef CFU_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_count <= '0;
    end else if (timeout_hit && (timeout_count != '1)) begin
      timeout_count <= timeout_count + TO_CNT_W'(1);
    end
  end
`else
  logic unused_timeout_hit;
  assign unused_timeout_hit = timeout_hit;
  assign timeout_count      = '0;
`endif

endmodule

// File: rtl/cfu_op_sequencer.sv
// CFU command sequencer: accepts CPU commands, issues them to a datapath and
// returns the result. Optional WAIT timeout enabled by CFU_SEQ_TIMEOUT_EN.
module cfu_op_sequencer
  import cfu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [6:0]  STATUS_FUNCT7  = STATUS_FUNCT7_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic        dp_en,
  output logic [6:0]  dp_cmd,
  output logic [31:0] dp_inp0,
  output logic [31:0] dp_inp1,
  input  logic [31:0] dp_ret,
  input  logic        dp_done
);

  seq_state_t          state, state_next;
  logic [6:0]          funct7;
  logic [6:0]          last_funct7;
  logic                rsp_load;
  logic [31:0]         rsp_next;
  logic                op_done;
  logic                timeout_hit;
  logic [OP_CNT_W-1:0] op_count;
  logic [TO_CNT_W-1:0] timeout_count;
  logic                unused_funct3;

  assign funct7        = cmd_payload_function_id[9:3];
  assign unused_funct3 = ^cmd_payload_function_id[2:0];

`ifdef CFU_SEQ_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_expired;

  assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state != ST_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end
`else
  localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    rsp_load    = 1'b0;
    rsp_next    = '0;
    op_done     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (funct7 == STATUS_FUNCT7) begin
            state_next = ST_RESP;
            rsp_load   = 1'b1;
            rsp_next   = status_word(op_count, timeout_count, last_funct7);
          end else begin
            state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE, ST_WAIT: begin
        // dp_done takes priority over a timeout expiring in the same cycle.
        if (dp_done) begin
          state_next = ST_RESP;
          rsp_load   = 1'b1;
          rsp_next   = dp_ret;
          op_done    = 1'b1;
        end else if (state == ST_ISSUE) begin
          state_next = ST_WAIT;
`ifdef CFU_SEQ_TIMEOUT_EN
        end else if (wait_expired) begin
          state_next  = ST_RESP;
          rsp_load    = 1'b1;
          rsp_next    = {TIMEOUT_TAG, 9'b0, dp_cmd};
          timeout_hit = 1'b1;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    dp_en     = (state == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_cmd                <= '0;
      dp_inp0               <= '0;
      dp_inp1               <= '0;
      last_funct7           <= '0;
      rsp_payload_outputs_0 <= '0;
    end else begin
      if (cmd_valid && (state == ST_IDLE)) begin
        dp_cmd  <= funct7;
        dp_inp0 <= cmd_payload_inputs_0;
        dp_inp1 <= cmd_payload_inputs_1;
      end
      if (state == ST_ISSUE) begin
        last_funct7 <= dp_cmd;
      end
      if (rsp_load) begin
        rsp_payload_outputs_0 <= rsp_next;
      end
    end
  end

  cfu_seq_counters u_counters (
    .clk           (clk),
    .reset_n       (reset_n),
    .op_done       (op_done),
    .timeout_hit   (timeout_hit),
    .op_count      (op_count),
    .timeout_count (timeout_count)
  );

endmodule

// File: tb/tb_cfu_op_sequencer.sv
// Directed bench for cfu_op_sequencer; timeout cases run only when
// CFU_SEQ_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=8).
module tb_cfu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id = '0;
  logic [31:0] cmd_payload_inputs_0 = '0;
  logic [31:0] cmd_payload_inputs_1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_payload_outputs_0;
  logic        dp_en;
  logic [6:0]  dp_cmd;
  logic [31:0] dp_inp0;
  logic [31:0] dp_inp1;
  logic [31:0] dp_ret = '0;
  logic        dp_done = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfu_op_sequencer #(
    .TIMEOUT_CYCLES (8),
    .STATUS_FUNCT7  (7'h7F)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .dp_en                   (dp_en),
    .dp_cmd                  (dp_cmd),
    .dp_inp0                 (dp_inp0),
    .dp_inp1                 (dp_inp1),
    .dp_ret                  (dp_ret),
    .dp_done                 (dp_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a datapath op; dly = cycles from dp_en to dp_done (0 = coincident).
  // Returns at the falling edge of the first response cycle.
  task automatic do_op(input string tag, input logic [6:0] f7, input logic [31:0] a,
                       input logic [31:0] b, input int unsigned dly, input logic [31:0] ret);
    step();
    cmd_valid = 1'b1;
    cmd_payload_function_id = {f7, 3'b010};
    cmd_payload_inputs_0 = a;
    cmd_payload_inputs_1 = b;
    @(negedge clk);
    check_eq({tag, ".cmd_ready"}, cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    if (dly == 0) begin
      dp_done = 1'b1;
      dp_ret  = ret;
    end
    @(negedge clk);
    check_eq({tag, ".dp_en"}, dp_en, 1);
    check_eq({tag, ".dp_cmd"}, dp_cmd, f7);
    check_eq({tag, ".dp_inp0"}, dp_inp0, a);
    check_eq({tag, ".dp_inp1"}, dp_inp1, b);
    for (int unsigned i = 1; i <= dly; i++) begin
      step();
      if (i == dly) begin
        dp_done = 1'b1;
        dp_ret  = ret;
      end
      @(negedge clk);
      check_eq({tag, ".wait_dp_en"}, dp_en, 0);
      check_eq({tag, ".wait_rsp_valid"}, rsp_valid, 0);
    end
    step();
    dp_done = 1'b0;
    dp_ret  = 32'hBAD0_BAD0;
    @(negedge clk);
    check_eq({tag, ".rsp_valid"}, rsp_valid, 1);
    check_eq({tag, ".payload"}, rsp_payload_outputs_0, ret);
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, ".rsp_done"}, rsp_valid, 0);
    check_eq({tag, ".ready_again"}, cmd_ready, 1);
  endtask

  task automatic do_status(input string tag, input logic [31:0] exp);
    step();
    cmd_valid = 1'b1;
    cmd_payload_function_id = {7'h7F, 3'b111};
    @(negedge clk);
    check_eq({tag, ".cmd_ready"}, cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, ".dp_en"}, dp_en, 0);
    check_eq({tag, ".rsp_valid"}, rsp_valid, 1);
    check_eq({tag, ".payload"}, rsp_payload_outputs_0, exp);
    finish_rsp(tag);
  endtask

  initial begin
    // reset state
    #3;
    check_eq("rst.rsp_valid", rsp_valid, 0);
    check_eq("rst.dp_en", dp_en, 0);
    check_eq("rst.payload", rsp_payload_outputs_0, 0);
    check_eq("rst.dp_cmd", dp_cmd, 0);
    check_eq("rst.dp_inp0", dp_inp0, 0);
    check_eq("rst.dp_inp1", dp_inp1, 0);
    repeat (2) step();
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst.cmd_ready", cmd_ready, 1);

    // dp_done four cycles after dp_en; response held for six cycles
    do_op("op1", 7'd3, 32'd5, 32'd7, 4, 32'h23);
    cmd_valid = 1'b1;
    cmd_payload_function_id = {7'h21, 3'b000};
    cmd_payload_inputs_0 = 32'h99;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      check_eq("hold.payload", rsp_payload_outputs_0, 32'h23);
      check_eq("hold.rsp_valid", rsp_valid, 1);
      check_eq("hold.cmd_ready", cmd_ready, 0);
      check_eq("hold.dp_en", dp_en, 0);
    end
    cmd_valid = 1'b0;
    check_eq("hold.dp_cmd_kept", dp_cmd, 7'd3);
    check_eq("hold.dp_inp0_kept", dp_inp0, 32'd5);
    finish_rsp("op1");

    // dp_done coincident with dp_en: WAIT skipped
    do_op("op2", 7'h11, 32'h1234, 32'h5678, 0, 32'h1);
    finish_rsp("op2");
    do_op("op3", 7'd3, 32'hFFFF_FFFF, 32'h0, 2, 32'hCAFE_BABE);
    finish_rsp("op3");
    do_status("stat1", 32'h0003_0006);

`ifdef CFU_SEQ_TIMEOUT_EN
    // no dp_done: timeout after 8 WAIT cycles
    step();
    cmd_valid = 1'b1;
    cmd_payload_function_id = {7'd3, 3'b000};
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("to.dp_en", dp_en, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge clk);
      check_eq("to.wait_rsp_valid", rsp_valid, 0);
    end
    step();
    @(negedge clk);
    check_eq("to.rsp_valid", rsp_valid, 1);
    check_eq("to.payload", rsp_payload_outputs_0, 32'hDEAD_0003);
    finish_rsp("to");
    do_status("stat_to", 32'h0003_0106);
    // dp_done on the expiry cycle wins over the timeout
    do_op("to_race", 7'd3, 32'd1, 32'd2, 8, 32'h55);
    finish_rsp("to_race");
    do_status("stat_race", 32'h0004_0106);
`endif

    // reset asserted mid-WAIT
    step();
    cmd_valid = 1'b1;
    cmd_payload_function_id = {7'd5, 3'b000};
    cmd_payload_inputs_0 = 32'hAAAA_0001;
    cmd_payload_inputs_1 = 32'hBBBB_0002;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("arst.rsp_valid", rsp_valid, 0);
    check_eq("arst.dp_en", dp_en, 0);
    check_eq("arst.payload", rsp_payload_outputs_0, 0);
    check_eq("arst.dp_cmd", dp_cmd, 0);
    check_eq("arst.dp_inp0", dp_inp0, 0);
    check_eq("arst.dp_inp1", dp_inp1, 0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("arst.cmd_ready", cmd_ready, 1);
    dp_done = 1'b1;
    dp_ret  = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check_eq("arst.no_rsp", rsp_valid, 0);
      check_eq("arst.idle_dp_en", dp_en, 0);
    end
    dp_done = 1'b0;
    do_status("stat_rst", 32'h0000_0000);
    do_op("op_after", 7'd9, 32'd10, 32'd20, 1, 32'h77);
    finish_rsp("op_after");
    do_status("stat_after", 32'h0001_0012);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
